// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: resolve kinds, prediction modes and the CPU word size.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package branch_predictor_pkg;

    localparam int BP_WORD_SIZE = `WORD_SIZE;

    typedef enum logic [1:0] {
        BP_COND = 2'd0,
        BP_JUMP = 2'd1,
        BP_JREG = 2'd2,
        BP_RSVD = 2'd3
    } bp_kind_e;

    localparam int PRED_STATIC_NT = 0;
    localparam int PRED_BTB_HIT   = 1;
    localparam int PRED_COUNTER   = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with load-value and load-max controls.
// Priority when several controls are asserted: set_val, set_max, inc, dec.
module sat_counter #(
    parameter int                  CTR_BITS  = 2,
    parameter logic [CTR_BITS-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                set_max_i,
    input  logic                set_val_i,
    input  logic [CTR_BITS-1:0] val_i,
    output logic [CTR_BITS-1:0] cnt_o
);

    logic [CTR_BITS-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets its default first so no path leaves it unassigned (avoids an inferred latch).
    always_comb begin
        cnt_d = cnt_q;
        if (set_val_i) begin
            cnt_d = val_i;
        end else if (set_max_i) begin
            cnt_d = '1;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CTR_BITS'(1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CTR_BITS'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters: zero-latency lookup for IF,
// resolve/mispredict check and table update for ID, plus prediction statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WORD_SIZE  = BP_WORD_SIZE,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int PRED_MODE  = PRED_COUNTER
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [1:0]           upd_kind,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_pred_taken,
    input  logic [WORD_SIZE-1:0] upd_pred_next_pc,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] correct_pc,
    output logic [WORD_SIZE-1:0] num_pred,
    output logic [WORD_SIZE-1:0] num_mispred
);

    localparam int                  ENTRIES     = 2 ** INDEX_BITS;
    localparam int                  TAG_BITS    = WORD_SIZE - INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(2 ** (CTR_BITS - 1));

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0]  ctr      [ENTRIES];

    logic [WORD_SIZE-1:0] num_pred_q, num_pred_d;
    logic [WORD_SIZE-1:0] num_mispred_q, num_mispred_d;

    // ---------------- Lookup ----------------
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;

    assign lk_idx   = if_pc[INDEX_BITS-1:0];
    assign lk_tag   = if_pc[WORD_SIZE-1:INDEX_BITS];
    assign pred_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        pred_taken = 1'b0;
        case (PRED_MODE)
            PRED_STATIC_NT: pred_taken = 1'b0;
            PRED_BTB_HIT:   pred_taken = pred_hit;
            PRED_COUNTER:   pred_taken = pred_hit && ctr[lk_idx][CTR_BITS-1];
            default:        pred_taken = 1'b0;
        endcase
    end

    assign pred_next_pc = pred_taken ? target_q[lk_idx] : if_pc + WORD_SIZE'(1);

    // ---------------- Resolve ----------------
    bp_kind_e              upd_kind_e;
    logic                  upd_en;
    logic                  is_cond;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;
    logic [WORD_SIZE-1:0]  actual_next;
    logic                  wr_entry;

    assign upd_kind_e  = bp_kind_e'(upd_kind);
    assign upd_en      = upd_valid && (upd_kind_e != BP_RSVD);
    assign is_cond     = (upd_kind_e == BP_COND);
    assign upd_idx     = upd_pc[INDEX_BITS-1:0];
    assign upd_tag     = upd_pc[WORD_SIZE-1:INDEX_BITS];
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign actual_next = upd_taken ? upd_target : upd_pc + WORD_SIZE'(1);
    assign mispredict  = upd_en && (actual_next != upd_pred_next_pc);
    assign correct_pc  = upd_en ? actual_next : '0;

    // The direction bit travels with the instruction for visibility only; redirects compare next PCs.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    // Jumps always (re)allocate; conditional branches only write on taken.
    assign wr_entry = upd_en && (!is_cond || upd_taken);

    // ---------------- Update ----------------
    always_comb begin
        valid_d       = valid_q;
        num_pred_d    = num_pred_q;
        num_mispred_d = num_mispred_q;
        if (wr_entry) begin
            valid_d[upd_idx] = 1'b1;
        end
        if (upd_en) begin
            num_pred_d = num_pred_q + WORD_SIZE'(1);
            if (mispredict) begin
                num_mispred_d = num_mispred_q + WORD_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            num_pred_q    <= '0;
            num_mispred_q <= '0;
        end else begin
            valid_q       <= valid_d;
            num_pred_q    <= num_pred_d;
            num_mispred_q <= num_mispred_d;
        end
    end

    // NOTE: tag/target storage is deliberately unreset; valid_q gates every read, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (wr_entry) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        logic sel;
        assign sel = upd_en && (upd_idx == INDEX_BITS'(i));

        sat_counter #(
            .CTR_BITS  (CTR_BITS),
            .RESET_VAL (CTR_WEAK_NT)
        ) u_ctr (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc_i     (sel && is_cond && upd_hit && upd_taken),
            .dec_i     (sel && is_cond && upd_hit && !upd_taken),
            .set_max_i (sel && !is_cond),
            .set_val_i (sel && is_cond && !upd_hit && upd_taken),
            .val_i     (CTR_WEAK_T),
            .cnt_o     (ctr[i])
        );
    end

    assign num_pred    = num_pred_q;
    assign num_mispred = num_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (counter mode): directed vector table,
// randomized traffic against a table-level reference model, and an asynchronous reset check.
module tb_branch_predictor;

    localparam int W  = 16;
    localparam int IB = 6;
    localparam int CB = 2;
    localparam int NE = 2 ** IB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  if_pc;
    logic          pred_hit, pred_taken;
    logic [W-1:0]  pred_next_pc;
    logic          upd_valid;
    logic [W-1:0]  upd_pc;
    logic [1:0]    upd_kind;
    logic          upd_taken;
    logic [W-1:0]  upd_target;
    logic          upd_pred_taken;
    logic [W-1:0]  upd_pred_next_pc;
    logic          mispredict;
    logic [W-1:0]  correct_pc, num_pred, num_mispred;

    branch_predictor #(
        .WORD_SIZE(W), .INDEX_BITS(IB), .CTR_BITS(CB), .PRED_MODE(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_next_pc(upd_pred_next_pc), .mispredict(mispredict), .correct_pc(correct_pc),
        .num_pred(num_pred), .num_mispred(num_mispred)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    bit m_valid [NE];
    int m_tag   [NE];
    int m_tgt   [NE];
    int m_ctr   [NE];
    int m_np, m_nm;

    task automatic m_clear();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 2 ** (CB - 1) - 1;
        end
        m_np = 0;
        m_nm = 0;
    endtask

    function automatic void m_lookup(input int pc, output logic hit, output logic taken,
                                     output logic [W-1:0] nxt);
        int i = pc % NE;
        hit   = m_valid[i] && (m_tag[i] == pc / NE);
        taken = hit && (m_ctr[i] >= 2 ** (CB - 1));
        nxt   = taken ? W'(m_tgt[i]) : W'((pc + 1) % 65536);
    endfunction

    function automatic void m_resolve(input logic uv, input int kind, input logic t, input int pc,
                                      input int tgt, input int pn, output logic mis,
                                      output logic [W-1:0] cpc);
        int actual = t ? tgt : (pc + 1) % 65536;
        mis = 0;
        cpc = '0;
        if (uv && kind != 3) begin
            mis = (actual != pn);
            cpc = W'(actual);
        end
    endfunction

    task automatic m_update(input logic uv, input int kind, input logic t, input int pc,
                            input int tgt, input int pn);
        int  i    = pc % NE;
        bit  hit  = m_valid[i] && (m_tag[i] == pc / NE);
        int  maxc = 2 ** CB - 1;
        logic            mis;
        logic [W-1:0]    cpc;
        if (!uv || kind == 3) return;
        m_resolve(uv, kind, t, pc, tgt, pn, mis, cpc);
        m_np = (m_np + 1) % 65536;
        if (mis) m_nm = (m_nm + 1) % 65536;
        if (kind == 0) begin
            if (hit) begin
                if (t) begin
                    m_ctr[i] = (m_ctr[i] < maxc) ? m_ctr[i] + 1 : maxc;
                    m_tgt[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (t) begin
                m_valid[i] = 1; m_tag[i] = pc / NE; m_tgt[i] = tgt; m_ctr[i] = 2 ** (CB - 1);
            end
        end else begin
            m_valid[i] = 1; m_tag[i] = pc / NE; m_tgt[i] = tgt; m_ctr[i] = maxc;
        end
    endtask

    // ---------------- Stimulus helpers ----------------
    typedef struct {
        logic [W-1:0] ipc;
        logic         uv;
        logic [1:0]   kind;
        logic         t;
        logic [W-1:0] upc, tgt, pn;
        logic         e_hit, e_taken;
        logic [W-1:0] e_next;
        logic         e_mis;
        logic [W-1:0] e_cpc;
    } vec_t;

    function automatic vec_t mkv(input logic [W-1:0] ipc, input logic uv, input logic [1:0] kind,
                                 input logic t, input logic [W-1:0] upc, tgt, pn,
                                 input logic e_hit, e_taken, input logic [W-1:0] e_next,
                                 input logic e_mis, input logic [W-1:0] e_cpc);
        vec_t v;
        v.ipc = ipc; v.uv = uv; v.kind = kind; v.t = t; v.upc = upc; v.tgt = tgt; v.pn = pn;
        v.e_hit = e_hit; v.e_taken = e_taken; v.e_next = e_next; v.e_mis = e_mis; v.e_cpc = e_cpc;
        return v;
    endfunction

    task automatic drive(input logic [W-1:0] ipc, input logic uv, input logic [1:0] kind,
                         input logic t, input logic [W-1:0] upc, tgt, pn);
        if_pc            = ipc;
        upd_valid        = uv;
        upd_kind         = kind;
        upd_taken        = t;
        upd_pc           = upc;
        upd_target       = tgt;
        upd_pred_next_pc = pn;
        upd_pred_taken   = (pn != upc + W'(1));
    endtask

    vec_t vecs[17];
    int   exp_np, exp_nm;

    initial begin
        reset_n = 1'b0;
        drive('0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence: allocation, counter walk, aliasing, same-cycle hazard, reserved kind, wrap.
        vecs[0]  = mkv(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0011, 0, 16'h0000);
        vecs[1]  = mkv(16'h0010, 1, 0, 1, 16'h0010, 16'h0004, 16'h0011, 0, 0, 16'h0011, 1, 16'h0004);
        vecs[2]  = mkv(16'h0010, 1, 0, 0, 16'h0010, 16'h0004, 16'h0004, 1, 1, 16'h0004, 1, 16'h0011);
        vecs[3]  = mkv(16'h0010, 1, 0, 0, 16'h0010, 16'h0004, 16'h0011, 1, 0, 16'h0011, 0, 16'h0011);
        vecs[4]  = mkv(16'h0010, 1, 0, 0, 16'h0010, 16'h0004, 16'h0011, 1, 0, 16'h0011, 0, 16'h0011);
        vecs[5]  = mkv(16'h0010, 1, 0, 1, 16'h0010, 16'h0004, 16'h0011, 1, 0, 16'h0011, 1, 16'h0004);
        vecs[6]  = mkv(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0011, 0, 16'h0000);
        vecs[7]  = mkv(16'h0010, 1, 1, 1, 16'h0050, 16'h0123, 16'h0051, 1, 0, 16'h0011, 1, 16'h0123);
        vecs[8]  = mkv(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0011, 0, 16'h0000);
        vecs[9]  = mkv(16'h0050, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0123, 0, 16'h0000);
        vecs[10] = mkv(16'h0020, 1, 1, 1, 16'h0020, 16'h0200, 16'h0021, 0, 0, 16'h0021, 1, 16'h0200);
        vecs[11] = mkv(16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000);
        vecs[12] = mkv(16'h0020, 1, 3, 1, 16'h0020, 16'h0300, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000);
        vecs[13] = mkv(16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000);
        vecs[14] = mkv(16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        vecs[15] = mkv(16'h0020, 1, 2, 1, 16'h0020, 16'h0400, 16'h0200, 1, 1, 16'h0200, 1, 16'h0400);
        vecs[16] = mkv(16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0400, 0, 16'h0000);

        exp_np = 0;
        exp_nm = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].ipc, vecs[i].uv, vecs[i].kind, vecs[i].t, vecs[i].upc, vecs[i].tgt, vecs[i].pn);
            #2;
            check($sformatf("v%0d pred_hit", i), pred_hit, vecs[i].e_hit);
            check($sformatf("v%0d pred_taken", i), pred_taken, vecs[i].e_taken);
            check($sformatf("v%0d pred_next_pc", i), pred_next_pc, vecs[i].e_next);
            check($sformatf("v%0d mispredict", i), mispredict, vecs[i].e_mis);
            check($sformatf("v%0d correct_pc", i), correct_pc, vecs[i].e_cpc);
            check($sformatf("v%0d num_pred", i), num_pred, exp_np);
            check($sformatf("v%0d num_mispred", i), num_mispred, exp_nm);
            @(posedge clk);
            #1;
            if (vecs[i].uv && vecs[i].kind != 2'd3) begin
                exp_np++;
                if (vecs[i].e_mis) exp_nm++;
            end
        end

        // Reset asserted between edges must clear statistics without a clock.
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("async rst num_pred", num_pred, 0);
        check("async rst num_mispred", num_mispred, 0);
        if_pc = 16'h0020;
        #1;
        check("async rst pred_hit", pred_hit, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_clear();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic [W-1:0] ipc, upc, tgt, pn, e_next, e_cpc, u_next;
            logic         uv, t, e_hit, e_taken, e_mis, u_hit, u_taken;
            logic [1:0]   k;
            ipc = ($urandom_range(0, 19) == 0) ? 16'hFFFF
                : W'($urandom_range(0, 3) * NE + $urandom_range(0, 7));
            upc = ($urandom_range(0, 19) == 0) ? 16'hFFFF
                : W'($urandom_range(0, 3) * NE + $urandom_range(0, 7));
            uv  = ($urandom_range(0, 9) != 0);
            k   = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            t   = (k == 2'd1 || k == 2'd2) ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = W'($urandom);
            m_lookup(int'(upc), u_hit, u_taken, u_next);
            pn  = ($urandom_range(0, 3) == 0) ? W'($urandom) : u_next;
            drive(ipc, uv, k, t, upc, tgt, pn);
            #2;
            m_lookup(int'(ipc), e_hit, e_taken, e_next);
            m_resolve(uv, int'(k), t, int'(upc), int'(tgt), int'(pn), e_mis, e_cpc);
            check($sformatf("r%0d pred_hit", c), pred_hit, e_hit);
            check($sformatf("r%0d pred_taken", c), pred_taken, e_taken);
            check($sformatf("r%0d pred_next_pc", c), pred_next_pc, e_next);
            check($sformatf("r%0d mispredict", c), mispredict, e_mis);
            check($sformatf("r%0d correct_pc", c), correct_pc, e_cpc);
            check($sformatf("r%0d num_pred", c), num_pred, m_np);
            check($sformatf("r%0d num_mispred", c), num_mispred, m_nm);
            @(posedge clk);
            #1;
            m_update(uv, int'(k), t, int'(upc), int'(tgt), int'(pn));
        end

        // Mid-run reset after a known allocation; updates held off while low.
        drive(16'h0033, 1'b1, 2'd1, 1'b1, 16'h0033, 16'h0777, 16'h0034);
        @(posedge clk);
        #1;
        drive(16'h0033, 1'b0, 2'd0, 1'b0, '0, '0, '0);
        #1;
        check("pre-rst hit 0x0033", pred_hit, 1);
        check("pre-rst num_pred nonzero", num_pred != 0, 1);
        reset_n = 1'b0;
        drive(16'h0033, 1'b1, 2'd1, 1'b1, 16'h0033, 16'h0777, 16'h0777);
        #1;
        check("rst pred_hit", pred_hit, 0);
        check("rst pred_taken", pred_taken, 0);
        check("rst pred_next_pc", pred_next_pc, 16'h0034);
        check("rst num_pred", num_pred, 0);
        check("rst num_mispred", num_mispred, 0);
        @(posedge clk);
        #1;
        check("rst held num_pred", num_pred, 0);
        check("rst held pred_hit", pred_hit, 0);
        drive(16'h0033, 1'b0, 2'd0, 1'b0, '0, '0, '0);
        @(negedge clk) reset_n = 1'b1;
        #1;
        check("post-rst pred_hit", pred_hit, 0);
        check("post-rst pred_next_pc", pred_next_pc, 16'h0034);
        check("post-rst num_pred", num_pred, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
